// File: rtl/i2s_rx_pkg.sv
// Shared types and defaults for the I2S receiver.
// Combinational only: no latency, no flow control.
package i2s_rx_pkg;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } i2s_state_t;

   localparam int   I2S_DEFAULT_DATA_BITS = 24;
   localparam int   I2S_DEFAULT_SLOT_BITS = 32;
   localparam logic I2S_CH_LEFT           = 1'b0;

endpackage

// File: rtl/i2s_sync.sv
// Pin synchroniser: 3 flops on the clock pin for rise detect, 2 on delay-matched aux pins.
// Latency 2 mclk to sync outputs, rise valid 2 mclk after pad edge; no backpressure.
module i2s_sync #(
   parameter int AUX_W = 2
) (
   input  logic             mclk,
   input  logic             reset_n,
   input  logic             sclk,
   input  logic [AUX_W-1:0] aux_in,
   output logic [AUX_W-1:0] aux_out,
   output logic             rise
);

   logic [2:0]       sclk_q;
   logic [AUX_W-1:0] aux_q1;
   logic [AUX_W-1:0] aux_q2;

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q <= '0;
         aux_q1 <= '0;
         aux_q2 <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         aux_q1 <= aux_in;
         aux_q2 <= aux_q1;
      end
   end

   assign aux_out = aux_q2;
   assign rise    = sclk_q[1] & ~sclk_q[2];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdin in mclk, emits MSB-aligned L/R pairs with a valid strobe.
// Latency 4 mclk from the pad bclk edge carrying the next left MSB; no backpressure, pairs are never stalled.
module i2s_rx
   import i2s_rx_pkg::*;
#(
   parameter int DATA_BITS = I2S_DEFAULT_DATA_BITS,
   parameter int SLOT_BITS = I2S_DEFAULT_SLOT_BITS
) (
   input  logic        mclk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        bclk,
   input  logic        lrclk,
   input  logic        sdin,
   input  logic        err_clr,
   output logic [31:0] xl,
   output logic [31:0] xr,
   output logic        valid,
   output logic        locked,
   output logic        frame_err
);

   localparam int CW = 7;
   localparam logic [DATA_BITS-1:0] MSB_BIT = {1'b1, {(DATA_BITS-1){1'b0}}};

   logic [1:0]           aux_s;
   logic                 bit_edge;
   logic                 w;
   logic                 d;
   logic                 w1;
   logic                 w2;
   logic                 ch_start;
   logic [DATA_BITS-1:0] word;
   logic [DATA_BITS-1:0] hold_l;
   logic [DATA_BITS-1:0] hold_r;
   logic [CW-1:0]        cnt;
   logic                 out_go;
   logic                 commit_l;
   logic                 commit_r;
   logic                 slot_bad;
   i2s_state_t           state;
   i2s_state_t           state_nxt;

   i2s_sync #(.AUX_W(2)) u_sync (
      .mclk    (mclk),
      .reset_n (reset_n),
      .sclk    (bclk),
      .aux_in  ({sdin, lrclk}),
      .aux_out (aux_s),
      .rise    (bit_edge)
   );

   assign w        = aux_s[0];
   assign d        = aux_s[1];
   // A word-select change seen one edge ago marks the MSB of the new channel.
   assign ch_start = bit_edge && (w1 != w2);
   assign slot_bad = (cnt < CW'(DATA_BITS)) || (cnt > CW'(SLOT_BITS));
   assign locked   = (state == LEFT) || (state == RIGHT);

   always_comb begin
      state_nxt = state;
      commit_l  = 1'b0;
      commit_r  = 1'b0;
      case (state)
         SEEK: begin
            if (ch_start && w1 == I2S_CH_LEFT) state_nxt = LEFT;
         end
         LEFT: begin
            if (ch_start && w1 != I2S_CH_LEFT) begin
               state_nxt = RIGHT;
               commit_l  = 1'b1;
            end
         end
         RIGHT: begin
            if (ch_start && w1 == I2S_CH_LEFT) begin
               state_nxt = LEFT;
               commit_r  = 1'b1;
            end
         end
         default: state_nxt = SEEK;
      endcase
      if (!en) begin
         state_nxt = SEEK;
         commit_l  = 1'b0;
         commit_r  = 1'b0;
      end
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) state <= SEEK;
      else          state <= state_nxt;
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         w1   <= 1'b0;
         w2   <= 1'b0;
         cnt  <= '0;
         word <= '0;
      end else if (bit_edge) begin
         w1 <= w;
         w2 <= w1;
         if (ch_start) begin
            word <= d ? MSB_BIT : '0;
            cnt  <= CW'(1);
         end else begin
            if (cnt < CW'(DATA_BITS) && d) word <= word | (MSB_BIT >> cnt);
            if (cnt < CW'(SLOT_BITS + 1))  cnt  <= cnt + CW'(1);
         end
      end
   end

   // Pair is published one cycle after the right commit so hold_r is settled.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         hold_l    <= '0;
         hold_r    <= '0;
         out_go    <= 1'b0;
         valid     <= 1'b0;
         xl        <= '0;
         xr        <= '0;
         frame_err <= 1'b0;
      end else begin
         if (commit_l) hold_l <= word;
         if (commit_r) hold_r <= word;
         out_go <= commit_r;
         valid  <= out_go && en;
         if (out_go && en) begin
            xl <= 32'(hold_l) << (32 - DATA_BITS);
            xr <= 32'(hold_r) << (32 - DATA_BITS);
         end
         if ((commit_l || commit_r) && slot_bad) frame_err <= 1'b1;
         else if (err_clr)                       frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised I2S stream against a slot-level reference; a monitor pops expected pairs on each valid.
// mclk = 8x bclk, DATA_BITS = 24, SLOT_BITS = 32.
module tb_i2s_rx;

   logic        mclk = 1'b0;
   logic        reset_n, en, bclk, lrclk, sdin, err_clr;
   logic [31:0] xl, xr;
   logic        valid, locked, frame_err;

   i2s_rx #(.DATA_BITS(24), .SLOT_BITS(32)) dut (
      .mclk      (mclk),
      .reset_n   (reset_n),
      .en        (en),
      .bclk      (bclk),
      .lrclk     (lrclk),
      .sdin      (sdin),
      .err_clr   (err_clr),
      .xl        (xl),
      .xr        (xr),
      .valid     (valid),
      .locked    (locked),
      .frame_err (frame_err)
   );

   always #5 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   int n_valid = 0;

   typedef struct {
      logic [31:0] xl;
      logic [31:0] xr;
      int          at;
      logic        err;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   // Reference state, tracked per slot rather than per bit.
   logic        m_lock, m_have_l, m_err, m_prev_ok, m_prev_ch;
   logic [23:0] m_prev_val;
   int          m_prev_n;
   logic [31:0] m_l, m_last_xl, m_last_xr;

   int slot_lens[7] = '{32, 32, 32, 24, 28, 33, 20};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] exp_word(input logic [23:0] v, input int n);
      int keep = (n < 24) ? n : 24;
      logic [23:0] mask;
      mask = 24'hFFFFFF << (24 - keep);
      return {v & mask, 8'h00};
   endfunction

   task automatic model_reset();
      m_lock = 0; m_have_l = 0; m_err = 0; m_prev_ok = 0; m_prev_ch = 0;
      m_prev_val = 0; m_prev_n = 0; m_l = 0; m_last_xl = 0; m_last_xr = 0;
   endtask

   task automatic model_start(input logic ch, input logic [23:0] val, input int n, input int tr);
      logic [31:0] wv;
      if (m_lock && m_prev_ok) begin
         wv = exp_word(m_prev_val, m_prev_n);
         if (m_prev_n < 24 || m_prev_n > 32) m_err = 1;
         if (m_prev_ch == 1'b0) begin
            m_l = wv;
            m_have_l = 1;
         end else if (m_have_l) begin
            q.push_back('{m_l, wv, tr + 4, m_err});
            m_last_xl = m_l;
            m_last_xr = wv;
            m_have_l = 0;
         end
      end
      if (ch == 1'b0) m_lock = 1;
      m_prev_ch  = ch;
      m_prev_val = val;
      m_prev_n   = n;
      m_prev_ok  = m_lock;
   endtask

   // One bclk period: data changes on the falling edge, 4 mclk low then 4 high.
   task automatic send_bit(input logic w, input logic d, output int tr);
      @(posedge mclk); #1;
      bclk = 0; lrclk = w; sdin = d;
      repeat (4) @(posedge mclk);
      #1 bclk = 1;
      tr = cyc;
      repeat (3) @(posedge mclk);
   endtask

   // ev_kind: 1 = drop en for 10 mclk, 2 = pulse reset, both just before bit ev_at.
   task automatic send_slot(input logic ch, input logic next_ch, input logic [23:0] val,
                            input int n, input int ev_at, input int ev_kind);
      int   tr;
      logic w, d;
      for (int i = 0; i < n; i++) begin
         if (i == ev_at && ev_kind == 1) begin
            @(posedge mclk); #1 en = 0;
            repeat (10) @(posedge mclk);
            #1;
            chk("locked_en_low", locked, 0);
            chk("xl_hold_en_low", xl, m_last_xl);
            chk("xr_hold_en_low", xr, m_last_xr);
            en = 1;
            m_lock = 0; m_have_l = 0; m_prev_ok = 0;
         end
         if (i == ev_at && ev_kind == 2) begin
            @(posedge mclk); #1 reset_n = 0;
            #1;
            chk("xl_mid_reset", xl, 0);
            chk("xr_mid_reset", xr, 0);
            chk("valid_mid_reset", valid, 0);
            chk("locked_mid_reset", locked, 0);
            chk("err_mid_reset", frame_err, 0);
            repeat (2) @(posedge mclk);
            #1 reset_n = 1;
            model_reset();
         end
         w = (i == n - 1) ? next_ch : ch;
         d = (i < 24) ? val[23 - i] : 1'($urandom);
         send_bit(w, d, tr);
         if (i == 0) model_start(ch, val, n, tr);
      end
   endtask

   task automatic pair(input logic [23:0] l, input int ln, input logic [23:0] r, input int rn);
      send_slot(1'b0, 1'b1, l, ln, -1, 0);
      send_slot(1'b1, 1'b0, r, rn, -1, 0);
      chk("locked_pair_end", locked, m_lock);
      chk("err_pair_end", frame_err, m_err);
   endtask

   task automatic pulse_err_clr();
      @(posedge mclk); #1 err_clr = 1;
      @(posedge mclk); #1 err_clr = 0;
      m_err = 0;
      chk("err_after_clr", frame_err, 0);
   endtask

   always @(negedge mclk) begin
      if (reset_n === 1'b1 && valid === 1'b1) begin
         n_valid++;
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("xl", xl, mon_e.xl);
            chk("xr", xr, mon_e.xr);
            chk("valid_cycle", 64'(cyc), 64'(mon_e.at));
            chk("err_at_valid", frame_err, mon_e.err);
         end
      end
   end

   initial begin
      int dummy;
      reset_n = 0; en = 1; bclk = 0; lrclk = 0; sdin = 0; err_clr = 0;
      model_reset();
      repeat (3) @(posedge mclk);
      for (int i = 0; i < 6; i++) send_bit(1'($urandom), 1'($urandom), dummy);
      #1;
      chk("xl_reset", xl, 0);
      chk("xr_reset", xr, 0);
      chk("valid_reset", valid, 0);
      chk("locked_reset", locked, 0);
      chk("err_reset", frame_err, 0);
      @(posedge mclk); #1 reset_n = 1;

      // Join mid right slot, then directed frames.
      send_slot(1'b1, 1'b0, 24'($urandom), 10, -1, 0);
      pair(24'h123456, 32, 24'hABCDEF, 32);
      chk("no_valid_before_pair", n_valid, 0);
      pair(24'hFFFFFF, 32, 24'h800000, 32);
      pair(24'hBEEF00, 16, 24'h000001, 32);
      pair(24'($urandom), 32, 24'($urandom), 32);
      pulse_err_clr();

      // Enable drop in the middle of a left slot.
      send_slot(1'b0, 1'b1, 24'($urandom), 32, 10, 1);
      send_slot(1'b1, 1'b0, 24'($urandom), 32, -1, 0);
      pair(24'($urandom), 32, 24'($urandom), 32);
      pair(24'($urandom), 32, 24'($urandom), 32);

      // Reset during bit 12 of a right slot.
      send_slot(1'b0, 1'b1, 24'($urandom), 32, -1, 0);
      send_slot(1'b1, 1'b0, 24'($urandom), 32, 12, 2);
      pair(24'h123456, 32, 24'hABCDEF, 32);

      for (int k = 0; k < 12; k++) begin
         pair(24'($urandom), slot_lens[$urandom_range(0, 6)],
              24'($urandom), slot_lens[$urandom_range(0, 6)]);
         if ($urandom_range(0, 3) == 0) pulse_err_clr();
      end

      send_slot(1'b0, 1'b1, 24'($urandom), 32, -1, 0);
      repeat (20) @(posedge mclk);
      #1;
      chk("all_pairs_seen", 64'(q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Serial audio receiver directly upstream of the DSP top level.
- Converts an external I2S stream (bclk, lrclk, sdin, all asynchronous to mclk) into the 32-bit parallel xl/xr samples the DSP consumes.
- Oversamples the I2S pins in the mclk domain; no second clock domain exists inside the block.
- Presents each left/right pair together with a one-cycle valid strobe.

Parameters:
- DATA_BITS, 24: captured bits per channel, MSB-first; legal range 16..32.
- SLOT_BITS, 32: nominal bclk cycles per channel slot; DATA_BITS <= SLOT_BITS <= 64.

Ports:
- mclk  in  1  system clock; must be at least 4x bclk frequency.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  receive enable; low forces resynchronisation.
- bclk  in  1  I2S bit clock (async).
- lrclk  in  1  I2S word select (async); 0 = left, 1 = right.
- sdin  in  1  I2S serial data (async).
- err_clr  in  1  one-cycle pulse, clears frame_err.
- xl  out  32  left sample; DATA_BITS MSB-aligned in [31:32-DATA_BITS], lower bits zero.
- xr  out  32  right sample; same format as xl.
- valid  out  1  one-mclk pulse when xl/xr update.
- locked  out  1  high while in LEFT or RIGHT state.
- frame_err  out  1  sticky slot-length error.

Behaviour:
- **Reset values:** xl = 0, xr = 0, valid = 0, locked = 0, frame_err = 0; state = SEEK; all internal registers cleared. Reset asserted mid-frame discards the partial word.
- **Synchronisers:** bclk, lrclk and sdin each pass through 2 flip-flops. A bclk rising edge is detected when synced stage 2 = 1 and stage 3 = 0. On the detect cycle ("bit edge"), sample w = synced lrclk and d = synced sdin.
- **Channel-start detection:** keep w1 = w from the previous bit edge and w2 = w from the edge before that. A bit edge with w1 != w2 is a channel start; its channel is w1. This implements the standard one-bclk I2S delay: the bit on this edge is the MSB of the new channel, and the bit on the previous edge was the LSB of the old one.
- **Per-channel capture:**
  - Word register is DATA_BITS wide, cleared at each channel start.
  - Counter cnt runs 0..SLOT_BITS+1, saturating.
  - Each bit edge: if cnt < DATA_BITS, write d into bit (DATA_BITS-1-cnt). Then cnt++.
  - Bits beyond DATA_BITS are ignored.
- **Commit:** at a channel start, before capturing the new MSB, the previous channel word is committed.
  - If the committed slot had cnt < DATA_BITS: the unfilled LSBs remain 0 and frame_err is set.
  - If cnt > SLOT_BITS: frame_err is set and the word is still used.
- **State machine:**
  - SEEK: ignore data. On a channel start with channel = 0 → LEFT (begin capture; no commit).
  - LEFT: on a channel start (channel = 1) → commit word to hold_l, go to RIGHT.
  - RIGHT: on a channel start (channel = 0) → commit the right word. On the next mclk: xl <= hold_l, xr <= right word, valid = 1 for one cycle. Go to LEFT.
  - en = 0 in any state: go to SEEK next cycle and drop the partial pair. xl/xr hold their values and no valid is issued.
- **Latency:** xl/xr/valid update exactly 4 mclk cycles after the pad-level bclk rising edge that carries the next left MSB (2 sync + 1 edge detect + 1 output register).
- **Stopped clocks:** if bclk stops, outputs hold indefinitely. There is no timeout; locked stays as is.
- **Error flag:** frame_err is cleared only by reset or err_clr. If err_clr coincides with a new error in the same cycle, set wins.
- **Output format:** xl/xr are raw two's-complement, MSB-aligned; no sign extension is needed.

Decomposition:
- Shared package contains:
  - state encoding: SEEK = 2'd0, LEFT = 2'd1, RIGHT = 2'd2;
  - I2S_DEFAULT_DATA_BITS = 24;
  - I2S_DEFAULT_SLOT_BITS = 32;
  - I2S_CH_LEFT = 1'b0.
- One sub-module, i2s_sync: 3-stage synchroniser with rise output.
  - Instantiated for bclk.
  - lrclk and sdin use its 2-stage data path so all three signals stay delay-matched.

Test Plan (DATA_BITS = 24, SLOT_BITS = 32, mclk = 8x bclk):
- Reset: hold reset_n low while toggling bclk → xl = xr = 0, valid = 0, locked = 0, frame_err = 0.
- Basic frame: start mid-right slot, then send L = 0x123456, R = 0xABCDEF, then a further left slot → no valid before the first full pair. Then xl = 0x12345600, xr = 0xABCDEF00, exactly one valid pulse 4 mclk after the left-MSB bclk edge; locked = 1.
- Negative/extreme values: L = 0xFFFFFF, R = 0x800000 → xl = 0xFFFFFF00, xr = 0x80000000; frame_err stays 0.
- Short slot: left slot of 16 bits carrying 0xBEEF, normal right 0x000001 → xl = 0xBEEF0000, xr = 0x00000100, frame_err = 1. After an err_clr pulse, frame_err = 0.
- Enable drop: deassert en mid-left slot for 10 mclk → locked = 0, xl/xr unchanged, no valid. Relocks on the next left start, and the first valid comes one full pair later.
- Reset mid-frame: assert reset_n low during bit 12 of the right slot → outputs clear immediately; after release, behaves as the basic-frame scenario.
